cpi_capture_ctrl: RTL and testbench

CPI_CAPTURE_CTRL -- requirements
Module: cpi_capture_ctrl

---
 rtl/cpi_capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_cpi_capture_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cpi_capture_ctrl.sv
// cpi_capture_ctrl: captures camera parallel-interface frames (RGB565 or grayscale) into a FWFT pixel FIFO.
module cpi_capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DEPTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_p_clk,
  input  logic                  io_href,
  input  logic                  io_vsync,
  input  logic [DATA_W-1:0]     io_data_in,
  input  logic                  io_start,
  input  logic                  io_stop,
  input  logic                  io_mode,
  input  logic                  io_continuous,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [2*DATA_W-1:0]   io_out_data,
  output logic                  io_busy,
  output logic                  io_frame_done,
  output logic                  io_frame_err,
  output logic                  io_overflow
);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] L_W = CW'(IMG_W);
  localparam logic [RW-1:0] L_H = RW'(IMG_H);
  localparam logic [AW:0]   L_D = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;
  state_t                r_state;
  logic                  r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic                  r_href_s1, r_href_s2, r_href_s3;
  logic                  r_vs_s1, r_vs_s2, r_vs_s3;
  logic [DATA_W-1:0]     r_data_s1, r_data_s2, r_hi;
  logic                  r_mode, r_cont, r_phase, r_push, r_frame_err, r_overflow;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [2*DATA_W-1:0]   r_pix;
  logic [2*DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]         r_wr, r_rd;
  logic [AW:0]           r_cnt;
  logic w_pclk_rise, w_href_fall, w_vs_rise, w_vs_fall, w_byte_ev, w_formed, w_start;
  logic w_full, w_empty, w_pop, w_wr;
  logic [2*DATA_W-1:0]   w_pix;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {r_pclk_s1, r_pclk_s2, r_pclk_s3} <= '0;
      {r_href_s1, r_href_s2, r_href_s3} <= '0;
      {r_vs_s1, r_vs_s2, r_vs_s3}       <= '0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      {r_pclk_s1, r_pclk_s2, r_pclk_s3} <= {io_p_clk, r_pclk_s1, r_pclk_s2};
      {r_href_s1, r_href_s2, r_href_s3} <= {io_href, r_href_s1, r_href_s2};
      {r_vs_s1, r_vs_s2, r_vs_s3}       <= {io_vsync, r_vs_s1, r_vs_s2};
      r_data_s1 <= io_data_in;
      r_data_s2 <= r_data_s1;
    end
  end
  assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
  assign w_href_fall = r_href_s3 & ~r_href_s2;
  assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
  assign w_vs_fall   = r_vs_s3 & ~r_vs_s2;
  assign w_byte_ev   = (r_state == S_CAPTURE) & w_pclk_rise & r_href_s2;
  assign w_formed    = w_byte_ev & (r_mode ? ~r_phase : r_phase);
  assign w_pix       = r_mode ? {{DATA_W{1'b0}}, r_data_s2} : {r_hi, r_data_s2};
  assign w_start     = (r_state == S_IDLE) & io_start;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_cont      <= 1'b0;
      r_phase     <= 1'b0;
      r_hi        <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_push      <= 1'b0;
      r_pix       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        S_IDLE: if (io_start) begin
          r_mode      <= io_mode;
          r_cont      <= io_continuous;
          r_frame_err <= 1'b0;
          r_state     <= S_ARM;
        end
        S_ARM: if (io_stop) r_state <= S_IDLE;
          else if (w_vs_fall) begin
            r_col   <= '0;
            r_row   <= '0;
            r_phase <= 1'b0;
            r_state <= S_CAPTURE;
          end
        S_CAPTURE: if (io_stop) begin
            r_phase <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_vs_rise) begin
            if (r_row < L_H) r_frame_err <= 1'b1;
            r_state <= S_DONE;
          end else if (w_byte_ev) begin
            r_phase <= ~r_phase;
            if (!r_phase) r_hi <= r_data_s2;
            if (w_formed) begin
              r_push <= (r_col < L_W) & (r_row < L_H);
              r_pix  <= w_pix;
              if (r_col < L_W) r_col <= r_col + 1'b1;
            end
          end else if (w_href_fall) begin
            r_phase <= 1'b0;
            if (r_col != '0) begin
              r_col <= '0;
              if (r_row < L_H) r_row <= r_row + 1'b1;
            end
          end
        S_DONE: r_state <= (!io_stop && r_cont) ? S_ARM : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // A push into a full FIFO still lands when a pop frees the head in the same cycle.
  assign w_full  = r_cnt == L_D;
  assign w_empty = r_cnt == '0;
  assign w_pop   = ~w_empty & io_out_ready;
  assign w_wr    = r_push & (~w_full | w_pop);
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr] <= r_pix;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_start) r_overflow <= 1'b0;
      else if (r_push & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end
  assign io_out_valid  = ~w_empty;
  assign io_out_data   = w_empty ? '0 : r_mem[r_rd];
  assign io_busy       = r_state != S_IDLE;
  assign io_frame_done = r_state == S_DONE;
  assign io_frame_err  = r_frame_err;
  assign io_overflow   = r_overflow;
endmodule

// File: tb/tb_cpi_capture_ctrl.sv
// tb_cpi_capture_ctrl: table-driven and randomized frame checks against a pixel-list reference model.
module tb_cpi_capture_ctrl;
  localparam int W = 4, H = 2, D = 4;
  logic clock = 0, reset = 1, p_clk = 0, href = 0, vsync = 1;
  logic [7:0] din = 0;
  logic start = 0, stop = 0, mode = 0, cont = 0, ready = 1;
  logic valid, busy, done, err, ovf;
  logic [15:0] dout;
  int errors = 0, checks = 0, done_cnt = 0, nl = 0;
  int llen [3];
  logic [7:0] fb [3][16];
  logic [15:0] got [$], exp_q [$];
  typedef struct {bit m; int lines; int bpl; bit rdy; int words; bit ferr; bit fovf;} vec_t;
  vec_t tv [5];
  always #5 clock = ~clock;
  cpi_capture_ctrl #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .io_p_clk(p_clk), .io_href(href), .io_vsync(vsync),
    .io_data_in(din), .io_start(start), .io_stop(stop), .io_mode(mode), .io_continuous(cont),
    .io_out_valid(valid), .io_out_ready(ready), .io_out_data(dout), .io_busy(busy),
    .io_frame_done(done), .io_frame_err(err), .io_overflow(ovf));
  always @(negedge clock) begin
    if (!reset && valid && ready) got.push_back(dout);
    if (!reset && done) done_cnt++;
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic tick(int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic pbyte(logic [7:0] b);
    p_clk = 0; din = b; tick(4);
    p_clk = 1; tick(4);
  endtask
  task automatic fill(int lines, int bpl, bit rnd);
    nl = lines;
    for (int l = 0; l < 3; l++) begin
      llen[l] = bpl;
      for (int b = 0; b < 16; b++) fb[l][b] = rnd ? 8'($urandom) : 8'(18 + 34 * (l * bpl + b));
    end
  endtask
  // Pixels are pairs (RGB565) or even-index bytes (gray); only the first W pixels of the first H non-empty lines are kept.
  function automatic bit model(bit m);
    int r = 0;
    for (int l = 0; l < nl; l++) begin
      int pix = 0;
      for (int b = 0; b < llen[l]; b++) begin
        if (m ? (b % 2 == 0) : (b % 2 == 1)) begin
          if (r < H && pix < W) exp_q.push_back(m ? {8'h00, fb[l][b]} : {fb[l][b-1], fb[l][b]});
          pix++;
        end
      end
      if (pix > 0 && r < H) r++;
    end
    return r < H;
  endfunction
  task automatic drive_frame();
    tick(4); vsync = 0; tick(8);
    for (int l = 0; l < nl; l++) begin
      href = 1;
      for (int b = 0; b < llen[l]; b++) pbyte(fb[l][b]);
      p_clk = 0; href = 0; tick(8);
    end
    vsync = 1; tick(12);
  endtask
  task automatic compare_q(string name);
    check({name, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s word%0d", name, i), got[i], exp_q[i]);
  endtask
  task automatic pulse_start();
    start = 1; tick(1); start = 0;
  endtask
  initial begin
    bit e;
    tv[0] = '{0, 2, 8, 1, 8, 0, 0};
    tv[1] = '{1, 2, 8, 1, 8, 0, 0};
    tv[2] = '{0, 3, 12, 1, 8, 0, 0};
    tv[3] = '{0, 2, 8, 0, 4, 0, 1};
    tv[4] = '{1, 1, 8, 1, 4, 1, 0};
    tick(3);
    check("reset outs", {valid, busy, done, err, ovf}, 5'b0);
    check("reset data", dout, 16'h0);
    reset = 0; tick(2);
    for (int i = 0; i < 5; i++) begin
      mode = tv[i].m; ready = tv[i].rdy;
      fill(tv[i].lines, tv[i].bpl, 0);
      got.delete(); exp_q.delete(); done_cnt = 0;
      e = model(mode);
      pulse_start();
      check($sformatf("t%0d busy", i), busy, 1);
      drive_frame();
      check($sformatf("t%0d done_cnt", i), done_cnt, 1);
      check($sformatf("t%0d frame_err", i), err, tv[i].ferr);
      check($sformatf("t%0d overflow", i), ovf, tv[i].fovf);
      check($sformatf("t%0d idle", i), busy, 0);
      if (!tv[i].rdy) begin
        check("t3 valid held", valid, 1);
        ready = 1; tick(10);
        while (exp_q.size() > D) void'(exp_q.pop_back());
      end
      check($sformatf("t%0d words", i), got.size(), tv[i].words);
      compare_q($sformatf("t%0d", i));
      if (i == 0 && got.size() > 0) check("t0 first word", got[0], 16'h1234);
      if (i == 1 && got.size() > 1) check("t1 second word", got[1], 16'h0056);
    end
    mode = 0; cont = 1; fill(2, 8, 0);
    got.delete(); exp_q.delete(); done_cnt = 0;
    e = model(0);
    pulse_start(); drive_frame();
    check("cont f1 done", done_cnt, 1);
    check("cont f1 err", err, 0);
    check("cont f1 busy", busy, 1);
    fill(1, 8, 1);
    e = model(0);
    drive_frame();
    check("cont f2 done", done_cnt, 2);
    check("cont f2 err", err, e);
    check("cont f2 busy", busy, 1);
    compare_q("cont");
    stop = 1; tick(1); stop = 0;
    check("stop idle", busy, 0);
    cont = 0;
    fill(1, 8, 0); got.delete(); done_cnt = 0;
    pulse_start(); tick(4); vsync = 0; tick(8); href = 1;
    for (int b = 0; b < 3; b++) pbyte(fb[0][b]);
    stop = 1; tick(1); stop = 0;
    check("stop mid busy", busy, 0);
    p_clk = 0; href = 0; tick(8); vsync = 1; tick(12);
    check("stop mid done", done_cnt, 0);
    check("stop mid words", got.size(), 1);
    if (got.size() > 0) check("stop mid word", got[0], {fb[0][0], fb[0][1]});
    ready = 0; fill(1, 10, 1);
    pulse_start(); tick(4); vsync = 0; tick(8); href = 1;
    for (int b = 0; b < 6; b++) pbyte(fb[0][b]);
    check("pre-reset valid", valid, 1);
    reset = 1; tick(1);
    check("mid reset outs", {valid, busy, done, err, ovf}, 5'b0);
    check("mid reset data", dout, 16'h0);
    tick(2); reset = 0; href = 0; p_clk = 0; vsync = 1; tick(4);
    ready = 1; mode = 1; fill(2, 8, 1);
    got.delete(); exp_q.delete(); done_cnt = 0;
    e = model(1);
    pulse_start(); drive_frame();
    check("post reset done", done_cnt, 1);
    check("post reset err", err, e);
    compare_q("post reset");
    for (int r = 0; r < 6; r++) begin
      mode = 1'($urandom % 2);
      fill(1 + int'($urandom % 3), 2 * (1 + int'($urandom % 6)), 1);
      got.delete(); exp_q.delete(); done_cnt = 0;
      e = model(mode);
      pulse_start(); drive_frame();
      check($sformatf("rnd%0d done", r), done_cnt, 1);
      check($sformatf("rnd%0d err", r), err, e);
      check($sformatf("rnd%0d ovf", r), ovf, 0);
      compare_q($sformatf("rnd%0d", r));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
